// File: rtl/bist_pkg.sv
// Shared BIST definitions: fault class codes, log entry metadata and helpers.
package bist_pkg;

   localparam int unsigned FAULT_TYPE_W = 3;
   localparam int unsigned HITS_W       = 4;
   localparam logic [HITS_W-1:0] HITS_MAX = '1;

   typedef enum logic [FAULT_TYPE_W-1:0] {
      FAULT_NONE        = 3'd0,
      FAULT_STUCK_AT_0  = 3'd1,
      FAULT_STUCK_AT_1  = 3'd2,
      FAULT_TRANSITION  = 3'd3,
      FAULT_COUPLING    = 3'd4,
      FAULT_ADDR_DECODE = 3'd5,
      FAULT_UNKNOWN     = 3'd6
   } fault_type_e;

   typedef struct packed {
      fault_type_e           ftype;
      logic [HITS_W-1:0]     hits;
   } log_meta_t;

   // Hit counter increment that holds at the maximum.
   function automatic logic [HITS_W-1:0] hits_sat_inc(input logic [HITS_W-1:0] h);
      return (h == HITS_MAX) ? h : h + HITS_W'(1);
   endfunction

endpackage

// File: rtl/fault_addr_cam.sv
// Parallel address compare over all log slots; popped head slot is masked out.
module fault_addr_cam #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = 10
) (
   input  logic [AW-1:0]             i_addr,
   input  logic [DEPTH-1:0][AW-1:0]  i_tags,
   input  logic [DEPTH-1:0]          i_valid,
   input  logic [DEPTH-1:0]          i_excl,
   output logic [DEPTH-1:0]          o_hit_c,
   output logic                      o_any_hit_c
);

   always_comb begin
      o_hit_c = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         o_hit_c[i] = i_valid[i] & ~i_excl[i] & (i_tags[i] == i_addr);
      end
   end

   assign o_any_hit_c = |o_hit_c;

endmodule

// File: rtl/bist_fault_log.sv
// Failure-capture log behind the memory BIST: merges repeat addresses, FIFO readout,
// saturating event/drop counters and a spare-row repairability flag.
module bist_fault_log
   import bist_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LOG_DEPTH  = 8,
   parameter int unsigned SPARE_ROWS = 4,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clear,
   input  logic                           fault_valid,
   input  logic [ADDR_WIDTH-1:0]          fault_addr,
   input  logic [DATA_WIDTH-1:0]          fault_expected,
   input  logic [DATA_WIDTH-1:0]          fault_actual,
   input  logic [FAULT_TYPE_W-1:0]        fault_type,
   output logic                           rd_valid,
   input  logic                           rd_ready,
   output logic [ADDR_WIDTH-1:0]          rd_addr,
   output logic [DATA_WIDTH-1:0]          rd_syndrome,
   output logic [FAULT_TYPE_W-1:0]        rd_type,
   output logic [HITS_W-1:0]              rd_hits,
   output logic [$clog2(LOG_DEPTH):0]     entry_count,
   output logic                           overflow,
   output logic [CNT_WIDTH-1:0]           event_count,
   output logic [CNT_WIDTH-1:0]           drop_count,
   output logic                           repairable
);

   localparam int unsigned PTR_W = $clog2(LOG_DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;
   localparam int unsigned REP_W = CNT_WIDTH + 1;

   logic [LOG_DEPTH-1:0]                   r_valid;
   logic [LOG_DEPTH-1:0][ADDR_WIDTH-1:0]   r_addr;
   logic [LOG_DEPTH-1:0][DATA_WIDTH-1:0]   r_syn;
   log_meta_t [LOG_DEPTH-1:0]              r_meta;
   logic [PTR_W-1:0]                       r_wr_ptr;
   logic [PTR_W-1:0]                       r_rd_ptr;
   logic [OCC_W-1:0]                       r_count;
   logic                                   r_overflow;
   logic [CNT_WIDTH-1:0]                   r_event_cnt;
   logic [CNT_WIDTH-1:0]                   r_drop_cnt;

   logic                                   w_pop;
   logic                                   w_full;
   logic [DATA_WIDTH-1:0]                  w_syn_in;
   logic [LOG_DEPTH-1:0]                   w_pop_mask;
   logic [LOG_DEPTH-1:0]                   w_hit;
   logic                                   w_any_hit;
   logic                                   w_alloc;
   logic                                   w_drop;

   assign w_pop    = (r_count != '0) & rd_ready;
   assign w_full   = (r_count == OCC_W'(LOG_DEPTH));
   assign w_syn_in = fault_expected ^ fault_actual;

   always_comb begin
      w_pop_mask           = '0;
      w_pop_mask[r_rd_ptr] = w_pop;
   end

   fault_addr_cam #(
      .DEPTH (LOG_DEPTH),
      .AW    (ADDR_WIDTH)
   ) u_cam (
      .i_addr      (fault_addr),
      .i_tags      (r_addr),
      .i_valid     (r_valid),
      .i_excl      (w_pop_mask),
      .o_hit_c     (w_hit),
      .o_any_hit_c (w_any_hit)
   );

   // A pop frees the head slot this cycle, so a full log can still accept a new address.
   assign w_alloc = fault_valid & ~w_any_hit & (~w_full | w_pop);
   assign w_drop  = fault_valid & ~w_any_hit & w_full & ~w_pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid     <= '0;
         r_addr      <= '0;
         r_syn       <= '0;
         r_meta      <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_event_cnt <= '0;
         r_drop_cnt  <= '0;
      end else if (clear) begin
         r_valid     <= '0;
         r_addr      <= '0;
         r_syn       <= '0;
         r_meta      <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_event_cnt <= '0;
         r_drop_cnt  <= '0;
      end else begin
         if (fault_valid && (r_event_cnt != '1)) begin
            r_event_cnt <= r_event_cnt + CNT_WIDTH'(1);
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != '1) begin
               r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
            end
         end
         for (int i = 0; i < int'(LOG_DEPTH); i++) begin
            if (fault_valid && w_hit[i]) begin
               r_syn[i]       <= r_syn[i] | w_syn_in;
               r_meta[i].hits <= hits_sat_inc(r_meta[i].hits);
            end
         end
         if (w_pop) begin
            r_valid[r_rd_ptr] <= 1'b0;
            r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
         end
         // Allocation follows the pop so a full-log swap leaves the slot valid.
         if (w_alloc) begin
            r_valid[r_wr_ptr]      <= 1'b1;
            r_addr[r_wr_ptr]       <= fault_addr;
            r_syn[r_wr_ptr]        <= w_syn_in;
            r_meta[r_wr_ptr].ftype <= fault_type_e'(fault_type);
            r_meta[r_wr_ptr].hits  <= HITS_W'(1);
            r_wr_ptr               <= r_wr_ptr + PTR_W'(1);
         end
         r_count <= r_count + OCC_W'(w_alloc) - OCC_W'(w_pop);
      end
   end

   assign rd_valid    = (r_count != '0);
   assign rd_addr     = r_addr[r_rd_ptr];
   assign rd_syndrome = r_syn[r_rd_ptr];
   assign rd_type     = r_meta[r_rd_ptr].ftype;
   assign rd_hits     = r_meta[r_rd_ptr].hits;
   assign entry_count = r_count;
   assign overflow    = r_overflow;
   assign event_count = r_event_cnt;
   assign drop_count  = r_drop_cnt;

   assign repairable  = (REP_W'(r_count) + REP_W'(r_drop_cnt)) <= REP_W'(SPARE_ROWS);

endmodule
